// File: rtl/bemicro_cv_led_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PWM output PIO.
// The Nios II data master drives the master side. The PIO is the slave side.
interface bemicro_cv_led_pwm_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/bemicro_cv_led_pwm.sv
// LED output PIO with the following features:
//  - a DATA register, with atomic set and clear aliases
//  - a global 8-bit PWM brightness
//  - an optional blink gate that counts in PWM frames
// out_port and readdata are both registered.
module bemicro_cv_led_pwm #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 196,
    parameter int INVERT   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    bemicro_cv_led_pwm_if.slave      bus,
    output logic [WIDTH-1:0]         out_port
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DUTY   = 3'd1;
    localparam logic [2:0] A_OUTSET = 3'd2;
    localparam logic [2:0] A_OUTCLR = 3'd3;
    localparam logic [2:0] A_BLINK  = 3'd4;

    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       duty_q, duty_d;
    logic [15:0]      blink_q, blink_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;

    logic             wr_s;
    logic             tick_s;
    logic             frame_end_s;
    logic             pwm_on_s;
    logic [WIDTH-1:0] wd_s;
    logic             unused_wd_s;

    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wd_s        = bus.writedata[WIDTH-1:0];
    assign unused_wd_s = ^bus.writedata;
    assign tick_s      = (prescale_q == PS_MAX);
    assign frame_end_s = tick_s & (pwm_cnt_q == 8'hFF);
    // A DUTY of FF is forced fully on so there is never a one-count dark glitch.
    assign pwm_on_s    = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_q);

    assign bus.readdata = readdata_q;
    assign out_port     = out_port_q;

    // Next state for bus-visible registers, read mux and LED output stage
    always_comb begin
        data_d  = data_q;
        duty_d  = duty_q;
        blink_d = blink_q;
        if (wr_s) begin
            case (bus.address)
                A_DATA:   data_d  = wd_s;
                A_DUTY:   duty_d  = bus.writedata[7:0];
                A_OUTSET: data_d  = data_q | wd_s;
                A_OUTCLR: data_d  = data_q & ~wd_s;
                A_BLINK:  blink_d = bus.writedata[15:0];
                default:  data_d  = data_q;
            endcase
        end else begin
            data_d = data_q;
        end

        case (bus.address)
            A_DATA:  readdata_d = 32'(data_q);
            A_DUTY:  readdata_d = {24'd0, duty_q};
            A_BLINK: readdata_d = {16'd0, blink_q};
            default: readdata_d = 32'd0;
        endcase

        out_port_d = (data_q & {WIDTH{pwm_on_s & blink_phase_q}}) ^ INV_MASK;
    end

    // Next state for the free-running prescaler, PWM counter and blink gate
    always_comb begin
        prescale_d    = tick_s ? {PS_W{1'b0}} : (prescale_q + {{(PS_W-1){1'b0}}, 1'b1});
        pwm_cnt_d     = tick_s ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wr_s && (bus.address == A_BLINK)) begin
            // A new period always restarts in the lit phase.
            blink_cnt_d   = 16'd0;
            blink_phase_d = 1'b1;
        end else if (blink_q == 16'd0) begin
            blink_cnt_d   = 16'd0;
            blink_phase_d = 1'b1;
        end else if (frame_end_s) begin
            if (blink_cnt_q == (blink_q - 16'd1)) begin
                blink_cnt_d   = 16'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 16'd1;
                blink_phase_d = blink_phase_q;
            end
        end else begin
            blink_cnt_d   = blink_cnt_q;
            blink_phase_d = blink_phase_q;
        end
    end

    // State registers. The asynchronous reset leaves every LED dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q        <= {WIDTH{1'b0}};
            duty_q        <= 8'hFF;
            blink_q       <= 16'd0;
            prescale_q    <= {PS_W{1'b0}};
            pwm_cnt_q     <= 8'd0;
            blink_cnt_q   <= 16'd0;
            blink_phase_q <= 1'b1;
            readdata_q    <= 32'd0;
            out_port_q    <= INV_MASK;
        end else begin
            data_q        <= data_d;
            duty_q        <= duty_d;
            blink_q       <= blink_d;
            prescale_q    <= prescale_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            readdata_q    <= readdata_d;
            out_port_q    <= out_port_d;
        end
    end

endmodule

// File: tb/tb_bemicro_cv_led_pwm.sv
// Directed bench for the LED PWM PIO.
// Instance A uses PRESCALE=1 and active-low LEDs.
// Instance B uses PRESCALE=3 and active-high LEDs.
// Both instances receive identical bus traffic.
module tb_bemicro_cv_led_pwm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_a, out_b;
    int         checks = 0;
    int         errors = 0;

    bemicro_cv_led_pwm_if bus_a ();
    bemicro_cv_led_pwm_if bus_b ();

    bemicro_cv_led_pwm #(.WIDTH(8), .PRESCALE(1), .INVERT(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .out_port(out_a));
    bemicro_cv_led_pwm #(.WIDTH(8), .PRESCALE(3), .INVERT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .out_port(out_b));

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_a.chipselect = 1'b0; bus_b.chipselect = 1'b0;
        bus_a.write_n    = 1'b1; bus_b.write_n    = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_a.address = a;  bus_b.address = a;
        bus_a.writedata = d; bus_b.writedata = d;
        bus_a.chipselect = 1'b1; bus_b.chipselect = 1'b1;
        bus_a.write_n = 1'b0; bus_b.write_n = 1'b0;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] ra, output logic [31:0] rb);
        @(negedge clk);
        bus_a.address = a; bus_b.address = a;
        @(negedge clk);
        ra = bus_a.readdata;
        rb = bus_b.readdata;
    endtask

    // Sample n cycles. Count lit cycles per instance and any partial LED patterns.
    task automatic measure(input int n, output int lit_a, output int lit_b, output int bad);
        lit_a = 0; lit_b = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_a == 8'h00) lit_a++;
            else if (out_a != 8'hFF) bad++;
            if (out_b == 8'hFF) lit_b++;
            else if (out_b != 8'h00) bad++;
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        int la, lb, bad, n;
        bit found;

        vecs[0]  = '{1'b0, 3'd0, 32'h0, 32'h0,  "rst_data"};
        vecs[1]  = '{1'b0, 3'd1, 32'h0, 32'hFF, "rst_duty"};
        vecs[2]  = '{1'b0, 3'd2, 32'h0, 32'h0,  "rst_outset"};
        vecs[3]  = '{1'b0, 3'd3, 32'h0, 32'h0,  "rst_outclr"};
        vecs[4]  = '{1'b0, 3'd4, 32'h0, 32'h0,  "rst_blink"};
        vecs[5]  = '{1'b0, 3'd5, 32'h0, 32'h0,  "rst_a5"};
        vecs[6]  = '{1'b0, 3'd6, 32'h0, 32'h0,  "rst_a6"};
        vecs[7]  = '{1'b0, 3'd7, 32'h0, 32'h0,  "rst_a7"};
        vecs[8]  = '{1'b1, 3'd0, 32'hA5, 32'h0, "w_data"};
        vecs[9]  = '{1'b0, 3'd0, 32'h0, 32'hA5, "data_a5"};
        vecs[10] = '{1'b1, 3'd2, 32'h0A, 32'h0, "w_outset"};
        vecs[11] = '{1'b0, 3'd0, 32'h0, 32'hAF, "data_af"};
        vecs[12] = '{1'b0, 3'd2, 32'h0, 32'h0,  "outset_rd0"};
        vecs[13] = '{1'b1, 3'd3, 32'h81, 32'h0, "w_outclr"};
        vecs[14] = '{1'b0, 3'd0, 32'h0, 32'h2E, "data_2e"};
        vecs[15] = '{1'b0, 3'd3, 32'h0, 32'h0,  "outclr_rd0"};
        vecs[16] = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0, "w_rsvd"};
        vecs[17] = '{1'b0, 3'd6, 32'h0, 32'h0,  "rsvd_rd0"};
        vecs[18] = '{1'b0, 3'd0, 32'h0, 32'h2E, "rsvd_data"};
        vecs[19] = '{1'b0, 3'd1, 32'h0, 32'hFF, "rsvd_duty"};
        vecs[20] = '{1'b0, 3'd4, 32'h0, 32'h0,  "rsvd_blink"};
        vecs[21] = '{1'b1, 3'd0, 32'hFFFFFF12, 32'h0, "w_data_wide"};
        vecs[22] = '{1'b0, 3'd0, 32'h0, 32'h12, "data_trunc"};
        vecs[23] = '{1'b1, 3'd2, 32'h0, 32'h0,  "w_outset0"};
        vecs[24] = '{1'b0, 3'd0, 32'h0, 32'h12, "outset0"};
        vecs[25] = '{1'b1, 3'd3, 32'h0, 32'h0,  "w_outclr0"};
        vecs[26] = '{1'b0, 3'd0, 32'h0, 32'h12, "outclr0"};
        vecs[27] = '{1'b1, 3'd1, 32'h1234, 32'h0, "w_duty"};
        vecs[28] = '{1'b0, 3'd1, 32'h0, 32'h34, "duty_trunc"};
        vecs[29] = '{1'b1, 3'd4, 32'hABCDE, 32'h0, "w_blink"};
        vecs[30] = '{1'b0, 3'd4, 32'h0, 32'hBCDE, "blink_trunc"};
        vecs[31] = '{1'b1, 3'd4, 32'h0, 32'h0,  "w_blink0"};
        vecs[32] = '{1'b0, 3'd4, 32'h0, 32'h0,  "blink_0"};
        vecs[33] = '{1'b1, 3'd1, 32'hFF, 32'h0, "w_duty_ff"};
        vecs[34] = '{1'b0, 3'd1, 32'h0, 32'hFF, "duty_ff"};

        bus_idle();
        bus_a.address = 3'd0; bus_b.address = 3'd0;
        bus_a.writedata = 32'd0; bus_b.writedata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_out_a", {24'd0, out_a}, 32'hFF);
        check("rst_out_b", {24'd0, out_b}, 32'h00);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_a", {24'd0, out_a}, 32'hFF);

        // Register map vectors
        for (int i = 0; i < 35; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wd);
            end else begin
                bus_read(vecs[i].addr, ra, rb);
                check({vecs[i].name, "_a"}, ra, vecs[i].exp);
                check({vecs[i].name, "_b"}, rb, vecs[i].exp);
            end
        end

        // PWM duty 64: 192 lit cycles in 768 for both prescalers
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'd64);
        @(negedge clk);
        measure(768, la, lb, bad);
        check("duty64_a", la, 32'd192);
        check("duty64_b", lb, 32'd192);
        check("duty64_clean", bad, 32'd0);

        bus_write(3'd1, 32'd0);
        @(negedge clk);
        measure(768, la, lb, bad);
        check("duty0_a", la, 32'd0);
        check("duty0_b", lb, 32'd0);

        bus_write(3'd1, 32'd255);
        @(negedge clk);
        measure(768, la, lb, bad);
        check("duty255_a", la, 32'd768);
        check("duty255_b", lb, 32'd768);
        check("duty255_clean", bad, 32'd0);

        // Blink period 2 frames on A: 512 dark, 512 lit
        bus_write(3'd4, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge clk);
            if (out_a == 8'hFF) found = 1'b1;
        end
        check("blink_found_off", {31'd0, found}, 32'd1);
        n = 1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (out_a != 8'hFF) break;
            n++;
        end
        check("blink_off_len", n, 32'd512);
        n = 1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (out_a != 8'h00) break;
            n++;
        end
        check("blink_on_len", n, 32'd512);

        // Rewrite BLINK mid-off-phase: lit on the next output update
        repeat (100) @(negedge clk);
        check("blink_mid_off", {24'd0, out_a}, 32'hFF);
        bus_write(3'd4, 32'd2);
        check("blink_wr_edge", {24'd0, out_a}, 32'hFF);
        @(negedge clk);
        check("blink_restart_on", {24'd0, out_a}, 32'h00);
        bus_write(3'd4, 32'd0);

        // Asynchronous reset mid-frame
        bus_write(3'd0, 32'h3C);
        @(negedge clk);
        check("pre_rst_a", {24'd0, out_a}, 32'hC3);
        check("pre_rst_b", {24'd0, out_b}, 32'h3C);
        bus_write(3'd4, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_a", {24'd0, out_a}, 32'hFF);
        check("async_rst_b", {24'd0, out_b}, 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd0, ra, rb);
        check("rst2_data", ra, 32'h0);
        bus_read(3'd1, ra, rb);
        check("rst2_duty", rb, 32'hFF);
        bus_read(3'd4, ra, rb);
        check("rst2_blink", ra, 32'h0);
        bus_write(3'd0, 32'hFF);
        @(negedge clk);
        check("rst2_on_a", {24'd0, out_a}, 32'h00);
        check("rst2_on_b", {24'd0, out_b}, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bemicro_cv_led_pwm.md
Name: bemicro_cv_led_pwm

Overview:
- Avalon-MM slave output PIO that drives the board LEDs; the write-direction counterpart of the push-button/switch input PIO.
- Holds an LED data register with atomic set/clear aliases, a global 8-bit PWM brightness and an optional blink gate.
- Sits on the Nios II data master in the Qsys system; out_port goes straight to the LED pins.

Parameters:
- WIDTH, 8, number of LED outputs (1..32).
- PRESCALE, 196, clk cycles per PWM count step (>=1); 50 MHz / 196 / 256 is about 1 kHz PWM.
- INVERT, 1, 1 = LEDs active-low (out_port bit = ~lit), 0 = active-high.

Ports:
- clk  input  1  system clock, single clock domain.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  LED drive, registered.

Behaviour:
- Register map:
  - 0 DATA rw, bits [WIDTH-1:0].
  - 1 DUTY rw, bits [7:0].
  - 2 OUTSET wo: DATA |= wd. Reads return 0.
  - 3 OUTCLEAR wo: DATA &= ~wd. Reads return 0.
  - 4 BLINK rw, bits [15:0] = period in PWM frames.
  - 5..7 reserved: writes ignored, reads return 0.
- Unused writedata bits are ignored. Unused readdata bits read 0.
- Reset values (asynchronous, on reset_n low):
  - DATA=0, DUTY=8'hFF, BLINK=0.
  - prescaler=0, pwm_cnt=0, blink_cnt=0, blink_phase=1 (on).
  - readdata=0, out_port={WIDTH{INVERT}} (all LEDs dark).
- Read path:
  - readdata <= mux(address) on every clk edge, independent of chipselect; no read strobe.
  - Read latency is 1 cycle, no wait states.
  - Register updates take effect on the edge after the write, so a read on the cycle following a write returns the new value.
- Prescaler:
  - Counts 0..PRESCALE-1; tick=1 when count==PRESCALE-1, then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- PWM:
  - 8-bit pwm_cnt increments on tick and wraps 255->0.
  - frame_end = tick and pwm_cnt==255.
  - pwm_on = (DUTY==8'hFF) ? 1 : (pwm_cnt < DUTY). DUTY=0 means always off; DUTY=255 means always on (no glitch).
- Blink:
  - BLINK==0: blink_phase is held at 1 and blink_cnt at 0.
  - Otherwise, on frame_end, blink_cnt increments. When blink_cnt==BLINK-1, blink_phase toggles and blink_cnt returns to 0.
  - Any write to BLINK clears blink_cnt and sets blink_phase=1 on the same edge.
- Output:
  - out_port <= (DATA & {WIDTH{pwm_on & blink_phase}}) ^ {WIDTH{INVERT}}.
  - This is one register stage after the DATA/DUTY/counter state.
- Boundary cases:
  - A write to DUTY does not reset pwm_cnt; the new compare applies from the next cycle.
  - OUTSET/OUTCLEAR with wd=0 leave DATA unchanged.
  - Reset asserted mid-frame returns everything to reset values immediately (asynchronous); counting resumes from 0 on the first edge after release.
  - Counters free-run regardless of bus activity.

Test Plan:
- Reset, then read all addresses -> 0, 0xFF, 0, 0, 0, 0, 0, 0 (1-cycle latency); out_port=8'hFF with INVERT=1.
- Write DATA=0xA5, OUTSET 0x0A, OUTCLEAR 0x81 -> DATA reads 0xA5, then 0xAF, then 0x2E; OUTSET/OUTCLEAR read back 0.
- PRESCALE=1, DATA=0xFF, DUTY=64, INVERT=0 -> out_port=0xFF for exactly 64 of every 256 cycles, period 256; DUTY=0 -> always 0x00; DUTY=255 -> constant 0xFF.
- PRESCALE=1, DUTY=255, BLINK=2 -> out_port on for 512 cycles, off for 512, repeating; writing BLINK mid-off-phase -> LEDs on on the next output update.
- Write DATA=0x3C, then assert reset_n low mid-frame for 1 cycle -> out_port all-off immediately, DATA=0, DUTY=0xFF, blink restarts in the on phase.
- Write to address 6 with 0xFFFFFFFF -> no register changes; address 6 reads 0; with WIDTH=8, writing DATA=0xFFFF_FF12 -> readback 0x12.
